fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage, directly upstream of the decode/control stage. It holds the program counter and issues one outstanding read at a time to instruction memory. Each returned 16-bit instruction is buffered with its PC and handed to decode over a valid/ready handshake; decode then extracts `instr[15:11]` for the control decoder. The block also handles redirects from branch and jump resolution, stops permanently on a decoded HALT, and flags misaligned redirect targets.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset; must be even.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_req` in/out: out 1: read request; memory accepts it in any cycle where it is high.
- `imem_addr` out 16: read address, always equal to the PC register.
- `imem_rvalid` in 1: read data valid; arrives 1 or more cycles after the accepted request.
- `imem_rdata` in 16: instruction word, qualified by `imem_rvalid`.
- `redirect` in 1: branch/jump taken; replaces the PC with `redirect_pc`.
- `redirect_pc` in 16: redirect target.
- `halt` in 1: decoder's halt flag for the instruction currently presented on `id_*`.
- `id_valid` out 1: `id_instr`, `id_pc` and `id_pc_plus2` are valid.
- `id_ready` in 1: decode accepts the presented instruction.
- `id_instr` out 16: buffered instruction.
- `id_pc` out 16: address of `id_instr`.
- `id_pc_plus2` out 16: `id_pc + 2`, mod 2^16.
- `halted` out 1: sticky; fetch stopped by HALT.
- `err` out 1: sticky; a redirect target was odd.

## Operation
- States: REQ, WAIT, FULL, DRAIN, HALT, ERR. Reset enters REQ.
- Reset values: pc = RESET_PC; `id_instr`, `id_pc`, `id_valid`, `halted`, `err` are all 0; `id_pc_plus2` = 2.
- `imem_req` = (state==REQ) & ~`redirect`.
- Redirect handling, in REQ, WAIT, FULL and DRAIN:
  - Redirect has the highest priority.
  - If `redirect_pc[0]`=1: set `err`, go to ERR, leave pc unchanged.
  - Otherwise pc <= `redirect_pc`.
- REQ:
  - Redirect: stay in REQ. No request was issued that cycle.
  - Otherwise go to WAIT.
- WAIT:
  - `imem_rvalid` & ~`redirect`: buffer `imem_rdata`, set `id_pc`=pc, go to FULL.
  - `imem_rvalid` & `redirect`: discard the data, go to REQ.
  - ~`imem_rvalid` & `redirect`: go to DRAIN.
- DRAIN (a stale response is still outstanding):
  - `imem_rvalid`: discard the data, go to REQ.
  - A further redirect updates pc and stays in DRAIN.
- FULL (`id_valid`=1):
  - Redirect: drop the buffer, go to REQ.
  - Else `id_ready` & `halt`: go to HALT, set `halted`.
  - Else `id_ready`: pc <= pc+2, go to REQ.
  - Else hold; `id_*` stay stable.
- HALT and ERR: `imem_req`=0 and `id_valid`=0. `redirect` and `imem_rvalid` are ignored. Only reset exits.
- A stray `imem_rvalid` in REQ, FULL, HALT or ERR is ignored.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000. `id_pc_plus2` wraps the same way.

## Timing
- `imem_req`/`imem_addr`: combinational from state, pc and `redirect`.
- All `id_*`, `halted` and `err` outputs are registered.
- First request: the first rising edge after `rst_n` deasserts finds REQ with `imem_req`=1 and `imem_addr`=RESET_PC.
- With 1-cycle memory: req at cycle N, `imem_rvalid` at N+1, `id_valid` at N+2.
- If consumed at N+2, the next request goes out at N+3. Steady-state throughput is 1 instruction per 3 cycles.
- Redirect in cycle C: next request at C+1 if no response is outstanding; otherwise the cycle after the stale `imem_rvalid`.
- `id_valid` drops the cycle after a redirect or consuming handshake.
- Asynchronous reset mid-fetch: all state clears immediately. Any later stale `imem_rvalid` is ignored until REQ has issued.

## Test plan
- Reset, RESET_PC=16'h0010, memory latency 1, `id_ready`=1, instrs 0x4001/0x4002 -> requests at 0x0010 then 0x0012; `id_pc`=0x0010 with `id_pc_plus2`=0x0012, then `id_pc`=0x0012; 3-cycle cadence.
- Hold `id_ready`=0 for 5 cycles while FULL -> `id_instr`/`id_pc` stable, `imem_req`=0, no pc change; release -> next request at pc+2.
- Latency 3; redirect to 0x0100 one cycle after a request at 0x0020 -> old response discarded, `id_valid` stays 0; next request at 0x0100; first `id_pc`=0x0100.
- Redirect to 0x0200 in the same cycle as `imem_rvalid` -> data dropped, `imem_req` with addr 0x0200 the next cycle.
- FULL with `id_ready`=1, `halt`=1 -> `halted`=1, `id_valid`=0; no further `imem_req` for 20 cycles despite redirects.
- Redirect to 0x0031 -> `err`=1, `imem_req` stays 0. Separately, pc=0xFFFE consumed -> next request at 0x0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory read in flight
// and hands each returned word, tagged with its PC, to decode over valid/ready.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_plus2,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_FULL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] id_instr_r;
  logic [15:0] id_pc_r;
  logic [15:0] id_pc_plus2_r;
  logic        id_valid_r;
  logic        halted_r;
  logic        err_r;

  logic        redir_live_s;
  logic        redir_ok_s;
  logic        redir_bad_s;

  // 16-bit wrapping PC increment shared by the PC register and id_pc_plus2.
  function automatic logic [15:0] pc_inc2(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  // Redirect qualification and the memory request, both combinational.
  always_comb begin
    redir_live_s = 1'b0;
    redir_ok_s   = 1'b0;
    redir_bad_s  = 1'b0;
    if ((state_r == ST_REQ) || (state_r == ST_WAIT) ||
        (state_r == ST_FULL) || (state_r == ST_DRAIN)) begin
      redir_live_s = redirect;
    end else begin
      redir_live_s = 1'b0;
    end
    if (redir_live_s) begin
      redir_bad_s = redirect_pc[0];
      redir_ok_s  = ~redirect_pc[0];
    end else begin
      redir_bad_s = 1'b0;
      redir_ok_s  = 1'b0;
    end
    imem_req  = (state_r == ST_REQ) & ~redirect;
    imem_addr = pc_r;
  end

  // Fetch FSM with the PC and every decode-facing output held in registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_REQ;
      pc_r          <= RESET_PC;
      id_instr_r    <= 16'h0000;
      id_pc_r       <= 16'h0000;
      id_pc_plus2_r <= 16'h0002;
      id_valid_r    <= 1'b0;
      halted_r      <= 1'b0;
      err_r         <= 1'b0;
    end else if (redir_bad_s) begin
      err_r      <= 1'b1;
      id_valid_r <= 1'b0;
      state_r    <= ST_ERR;
    end else if (redir_ok_s) begin
      pc_r       <= redirect_pc;
      id_valid_r <= 1'b0;
      // A read still in flight must be swallowed before the new target is fetched.
      if (((state_r == ST_WAIT) || (state_r == ST_DRAIN)) && !imem_rvalid) begin
        state_r <= ST_DRAIN;
      end else begin
        state_r <= ST_REQ;
      end
    end else begin
      case (state_r)
        ST_REQ: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            id_instr_r    <= imem_rdata;
            id_pc_r       <= pc_r;
            id_pc_plus2_r <= pc_inc2(pc_r);
            id_valid_r    <= 1'b1;
            state_r       <= ST_FULL;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_FULL: begin
          if (id_ready) begin
            id_valid_r <= 1'b0;
            if (halt) begin
              halted_r <= 1'b1;
              state_r  <= ST_HALT;
            end else begin
              pc_r    <= pc_inc2(pc_r);
              state_r <= ST_REQ;
            end
          end else begin
            state_r <= ST_FULL;
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        ST_ERR: begin
          state_r <= ST_ERR;
        end
        default: begin
          id_valid_r <= 1'b0;
          err_r      <= 1'b1;
          state_r    <= ST_ERR;
        end
      endcase
    end
  end

  assign id_valid    = id_valid_r;
  assign id_instr    = id_instr_r;
  assign id_pc       = id_pc_r;
  assign id_pc_plus2 = id_pc_plus2_r;
  assign halted      = halted_r;
  assign err         = err_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a per-cycle vector table, directed corner sequences and
// randomized traffic checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus2;
  logic        halted;
  logic        err;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.RESET_PC(16'h0010)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus2(id_pc_plus2),
    .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what the fetch stage holds, not how it encodes it.
  logic [15:0] m_pc, m_buf, m_bpc;
  logic        m_full, m_out, m_stale, m_halted, m_err;
  // Memory: at most one read in flight.
  logic        mem_pend;
  int          mem_due;
  logic [15:0] mem_data;
  int          lat;
  int          cyc;
  logic        stray;
  // Values sampled by the last step.
  logic        s_req, s_valid, s_halted, s_err;
  logic [15:0] s_addr, s_instr, s_pc, s_p2;

  typedef struct {
    logic        rvalid;
    logic [15:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
  } vec_t;
  vec_t vec[7];

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0000; id_ready = 1'b0; halt = 1'b0;
    stray = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    mem_pend = 1'b0; cyc = 0;
    m_pc = 16'h0010; m_buf = 16'h0000; m_bpc = 16'h0000;
    m_full = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_halted = 1'b0; m_err = 1'b0;
    @(posedge clk); #3;
    chk("rst_valid", id_valid, 16'd0);
    chk("rst_instr", id_instr, 16'h0000);
    chk("rst_pc", id_pc, 16'h0000);
    chk("rst_pc_plus2", id_pc_plus2, 16'h0002);
    chk("rst_halted", halted, 16'd0);
    chk("rst_err", err, 16'd0);
    chk("rst_addr", imem_addr, 16'h0010);
    chk("rst_req", imem_req, 16'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: memory drives, outputs are checked mid-cycle, model advances.
  task automatic step();
    logic exp_req;
    if (mem_pend && cyc >= mem_due) begin
      imem_rvalid = 1'b1; imem_rdata = mem_data; mem_pend = 1'b0;
    end else if (stray && !mem_pend) begin
      imem_rvalid = 1'b1; imem_rdata = 16'($urandom);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = 16'($urandom);
    end
    #4;
    s_req = imem_req; s_addr = imem_addr; s_valid = id_valid; s_instr = id_instr;
    s_pc = id_pc; s_p2 = id_pc_plus2; s_halted = halted; s_err = err;
    exp_req = !m_halted && !m_err && !m_full && !m_out && !redirect;
    chk("imem_req", s_req, exp_req);
    chk("imem_addr", s_addr, m_pc);
    chk("id_valid", s_valid, m_full);
    if (m_full) begin
      chk("id_instr", s_instr, m_buf);
      chk("id_pc", s_pc, m_bpc);
      chk("id_pc_plus2", s_p2, m_bpc + 16'd2);
    end
    chk("halted", s_halted, m_halted);
    chk("err", s_err, m_err);
    if (s_req) begin
      mem_pend = 1'b1; mem_due = cyc + lat; mem_data = memf(s_addr);
    end
    if (!m_halted && !m_err) begin
      if (redirect) begin
        if (m_out && imem_rvalid) m_out = 1'b0;
        m_full = 1'b0;
        if (redirect_pc[0]) begin
          m_err = 1'b1;
        end else begin
          m_pc = redirect_pc;
          if (m_out) m_stale = 1'b1;
        end
      end else if (exp_req) begin
        m_out = 1'b1; m_stale = 1'b0;
      end else if (m_out && imem_rvalid) begin
        m_out = 1'b0;
        if (!m_stale) begin
          m_full = 1'b1; m_buf = imem_rdata; m_bpc = m_pc;
        end
      end else if (m_full && id_ready) begin
        m_full = 1'b0;
        if (halt) m_halted = 1'b1;
        else m_pc = m_pc + 16'd2;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int n;
    int nreq;
    logic [15:0] pc0, instr0, t;

    vec[0] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0000};
    vec[1] = '{1'b1, 16'h4001, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000, 16'h0000};
    vec[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b1, 16'h4001, 16'h0010};
    vec[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 1'b0, 16'h0000, 16'h0000};
    vec[4] = '{1'b1, 16'h4002, 1'b1, 1'b0, 16'h0012, 1'b0, 16'h0000, 16'h0000};
    vec[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 1'b1, 16'h4002, 16'h0012};
    vec[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0014, 1'b0, 16'h0000, 16'h0000};

    // Basic cadence from the vector table, one-cycle memory.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      imem_rvalid = vec[i].rvalid; imem_rdata = vec[i].rdata; id_ready = vec[i].ready;
      #4;
      chk($sformatf("vec%0d_req", i), imem_req, vec[i].exp_req);
      chk($sformatf("vec%0d_addr", i), imem_addr, vec[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), id_valid, vec[i].exp_valid);
      if (vec[i].exp_valid) begin
        chk($sformatf("vec%0d_instr", i), id_instr, vec[i].exp_instr);
        chk($sformatf("vec%0d_pc", i), id_pc, vec[i].exp_pc);
        chk($sformatf("vec%0d_pc_plus2", i), id_pc_plus2, vec[i].exp_pc + 16'd2);
      end
      @(posedge clk); #1;
    end

    // Decode stalls for several cycles while FULL.
    do_reset(); lat = 1; id_ready = 1'b0;
    n = 0; s_valid = 1'b0;
    while (!s_valid && n < 10) begin step(); n++; end
    chk("stall_fill", s_valid, 16'd1);
    pc0 = s_pc; instr0 = s_instr;
    for (int i = 0; i < 5; i++) step();
    chk("stall_pc_stable", s_pc, pc0);
    chk("stall_instr_stable", s_instr, instr0);
    id_ready = 1'b1; step(); step();
    chk("stall_next_req", s_req, 16'd1);
    chk("stall_next_addr", s_addr, pc0 + 16'd2);

    // Redirect while a slow read is outstanding.
    do_reset(); lat = 3; id_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0020; step();
    redirect = 1'b0; step();
    chk("drain_req0", s_req, 16'd1);
    chk("drain_addr0", s_addr, 16'h0020);
    redirect = 1'b1; redirect_pc = 16'h0100; step();
    redirect = 1'b0;
    n = 0; s_valid = 1'b0;
    while (!s_valid && n < 20) begin step(); n++; end
    chk("drain_got_valid", s_valid, 16'd1);
    chk("drain_first_pc", s_pc, 16'h0100);

    // Redirect in the same cycle as the response.
    do_reset(); lat = 1; id_ready = 1'b1;
    step();
    chk("same_req0", s_req, 16'd1);
    redirect = 1'b1; redirect_pc = 16'h0200; step();
    redirect = 1'b0; step();
    chk("same_req1", s_req, 16'd1);
    chk("same_addr1", s_addr, 16'h0200);
    chk("same_valid", s_valid, 16'd0);

    // HALT is permanent.
    do_reset(); lat = 1; id_ready = 1'b1; halt = 1'b1;
    n = 0; s_halted = 1'b0;
    while (!s_halted && n < 10) begin step(); n++; end
    chk("halt_set", s_halted, 16'd1);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      redirect = 1'($urandom); redirect_pc = 16'($urandom);
      step();
      nreq += int'(s_req);
    end
    redirect = 1'b0;
    chk("halt_no_req", 16'(nreq), 16'd0);
    chk("halt_no_err", s_err, 16'd0);
    chk("halt_no_valid", s_valid, 16'd0);

    // Odd redirect target.
    do_reset(); lat = 1;
    redirect = 1'b1; redirect_pc = 16'h0031; step();
    redirect = 1'b0; step();
    chk("odd_err", s_err, 16'd1);
    nreq = 0;
    for (int i = 0; i < 5; i++) begin step(); nreq += int'(s_req); end
    chk("odd_no_req", 16'(nreq), 16'd0);

    // PC wraps from 0xFFFE to 0x0000.
    do_reset(); lat = 2; id_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFE; step();
    redirect = 1'b0;
    n = 0; s_valid = 1'b0;
    while (!s_valid && n < 10) begin step(); n++; end
    chk("wrap_pc", s_pc, 16'hFFFE);
    chk("wrap_pc_plus2", s_p2, 16'h0000);
    n = 0; s_req = 1'b0;
    while (!s_req && n < 5) begin step(); n++; end
    chk("wrap_req", s_req, 16'd1);
    chk("wrap_addr", s_addr, 16'h0000);

    // Asynchronous reset while holding an instruction.
    do_reset(); lat = 1; id_ready = 1'b0;
    n = 0; s_valid = 1'b0;
    while (!s_valid && n < 10) begin step(); n++; end
    #2; rst_n = 1'b0; #1;
    chk("async_valid", id_valid, 16'd0);
    chk("async_pc", id_pc, 16'h0000);
    chk("async_pc_plus2", id_pc_plus2, 16'h0002);
    chk("async_addr", imem_addr, 16'h0010);
    chk("async_req", imem_req, 16'd1);
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      lat = int'($urandom_range(1, 3));
      for (int c = 0; c < 250; c++) begin
        redirect = ($urandom_range(0, 9) == 0);
        t = 16'($urandom);
        t[0] = ($urandom_range(0, 29) == 0);
        redirect_pc = t;
        id_ready = ($urandom_range(0, 2) != 0);
        halt = ($urandom_range(0, 59) == 0);
        stray = ($urandom_range(0, 7) == 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
